// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared definitions for the data-memory bus arbiter: master IDs, idle owner code,
// arbiter state encoding and a modulo-3 increment helper.
package dmem_bus_arbiter_pkg;

  localparam logic [1:0] MST_CPU    = 2'd0;
  localparam logic [1:0] MST_STACK  = 2'd1;
  localparam logic [1:0] MST_DBG    = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'b11;

  typedef enum logic {
    ARB_IDLE,
    ARB_ACCESS
  } arb_state_e;

  // Next master index, wrapping 2 -> 0; the unused code 3 also maps to 0.
  function automatic logic [1:0] mod3_inc(input logic [1:0] v);
    return (v >= MST_DBG) ? MST_CPU : v + 2'd1;
  endfunction

endpackage

// File: rtl/dmem_bus_arbiter_rr_pick3.sv
// Round-robin picker for three requesters: first requester at or after the pointer.
module dmem_bus_arbiter_rr_pick3
  import dmem_bus_arbiter_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic       o_found,
  output logic [1:0] o_winner
);

  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  assign w_c0 = (i_ptr == OWNER_NONE) ? MST_CPU : i_ptr;
  assign w_c1 = mod3_inc(w_c0);
  assign w_c2 = mod3_inc(w_c1);

  // Scan the three candidates in rotated order; the earliest requester wins.
  always_comb begin
    o_found  = 1'b1;
    o_winner = w_c0;
    if (i_req[w_c0]) begin
      o_winner = w_c0;
    end else if (i_req[w_c1]) begin
      o_winner = w_c1;
    end else if (i_req[w_c2]) begin
      o_winner = w_c2;
    end else begin
      o_found  = 1'b0;
      o_winner = MST_CPU;
    end
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Data-memory bus arbiter for CPU, stack unit and debug/DMA masters. Round-robin with
// a bounded lock for back-to-back beats and programmable wait states per access.
module dmem_bus_arbiter
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned LOCK_MAX    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] wr,
  input  logic [2:0] lock,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] addr2,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic [7:0] wdata2,
  output logic [2:0] grant,
  output logic [7:0] rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_wr,
  output logic       mem_rd,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic [1:0] owner
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);
  localparam logic [3:0] LockMax  = 4'(LOCK_MAX);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic [1:0] r_owner;
  logic [1:0] w_owner_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic [3:0] r_wait;
  logic [3:0] w_wait_nxt;
  logic [3:0] r_lock_cnt;
  logic [3:0] w_lock_cnt_nxt;

  logic       w_own_req;
  logic       w_own_wr;
  logic       w_own_lock;
  logic [7:0] w_own_addr;
  logic [7:0] w_own_wdata;

  logic       w_in_access;
  logic       w_abort;
  logic       w_done;
  logic       w_cont;
  logic [1:0] w_pick_ptr;
  logic       w_found;
  logic [1:0] w_winner;

  // Select the current owner's request, direction, lock, address and data.
  always_comb begin
    w_own_req   = 1'b0;
    w_own_wr    = 1'b0;
    w_own_lock  = 1'b0;
    w_own_addr  = 8'h00;
    w_own_wdata = 8'h00;
    case (r_owner)
      MST_CPU: begin
        w_own_req = req[0]; w_own_wr = wr[0]; w_own_lock = lock[0];
        w_own_addr = addr0; w_own_wdata = wdata0;
      end
      MST_STACK: begin
        w_own_req = req[1]; w_own_wr = wr[1]; w_own_lock = lock[1];
        w_own_addr = addr1; w_own_wdata = wdata1;
      end
      MST_DBG: begin
        w_own_req = req[2]; w_own_wr = wr[2]; w_own_lock = lock[2];
        w_own_addr = addr2; w_own_wdata = wdata2;
      end
      default: ;
    endcase
  end

  // A dropped request abandons the beat, even in what would be the completion cycle.
  assign w_in_access = (r_state == ARB_ACCESS);
  assign w_abort     = w_in_access & ~w_own_req;
  assign w_done      = w_in_access & w_own_req & (r_wait == 4'd0);
  assign w_cont      = w_done & w_own_lock & (r_lock_cnt < LockMax);
  // Completed beats that release the bus arbitrate from the advanced pointer.
  assign w_pick_ptr  = (w_done & ~w_cont) ? mod3_inc(r_owner) : r_ptr;

  dmem_bus_arbiter_rr_pick3 u_pick (
    .i_req    (req),
    .i_ptr    (w_pick_ptr),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  // Output decode; reset suppresses any completion strobe in the reset cycle.
  assign grant     = (w_done && !rst) ? (3'b001 << r_owner) : 3'b000;
  assign mem_wr    = w_done & ~rst & w_own_wr;
  assign mem_rd    = w_in_access & ~w_own_wr;
  assign busy      = w_in_access;
  assign mem_addr  = w_in_access ? w_own_addr : 8'h00;
  assign mem_wdata = w_in_access ? w_own_wdata : 8'h00;
  assign owner     = r_owner;
  assign rdata     = mem_rdata;

  // Next-state logic: arbitration, wait countdown, lock continuation and abort.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_ptr_nxt      = r_ptr;
    w_wait_nxt     = r_wait;
    w_lock_cnt_nxt = r_lock_cnt;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_state_nxt    = ARB_ACCESS;
          w_owner_nxt    = w_winner;
          w_wait_nxt     = WaitLoad;
          w_lock_cnt_nxt = 4'd1;
        end
      end
      ARB_ACCESS: begin
        if (w_abort || (w_done && !w_cont)) begin
          if (w_done) begin
            w_ptr_nxt = mod3_inc(r_owner);
          end
          if (w_found) begin
            w_owner_nxt    = w_winner;
            w_wait_nxt     = WaitLoad;
            w_lock_cnt_nxt = 4'd1;
          end else begin
            w_state_nxt    = ARB_IDLE;
            w_owner_nxt    = OWNER_NONE;
            w_wait_nxt     = 4'd0;
            w_lock_cnt_nxt = 4'd0;
          end
        end else if (w_cont) begin
          w_wait_nxt     = WaitLoad;
          w_lock_cnt_nxt = r_lock_cnt + 4'd1;
        end else begin
          w_wait_nxt = r_wait - 4'd1;
        end
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_owner    <= OWNER_NONE;
      r_ptr      <= MST_CPU;
      r_wait     <= 4'd0;
      r_lock_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_wait     <= w_wait_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench: instance A runs with no wait states, instance B with two; both share
// the master-side stimulus and each scenario checks the instance it targets.
module tb_dmem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req, wr, lock;
  logic [7:0] addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata;

  logic [2:0] grant_a, grant_b;
  logic [7:0] rdata_a, rdata_b, mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b;
  logic       mem_wr_a, mem_wr_b, mem_rd_a, mem_rd_b, busy_a, busy_b;
  logic [1:0] owner_a, owner_b;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_a    = 0;
  int cnt_b    = 0;

  always #5 clk = ~clk;

  dmem_bus_arbiter #(.WAIT_STATES(0), .LOCK_MAX(2)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .lock(lock),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .grant(grant_a), .rdata(rdata_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_wr(mem_wr_a), .mem_rd(mem_rd_a), .mem_rdata(mem_rdata),
    .busy(busy_a), .owner(owner_a)
  );

  dmem_bus_arbiter #(.WAIT_STATES(2), .LOCK_MAX(2)) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .lock(lock),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .grant(grant_b), .rdata(rdata_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_wr(mem_wr_b), .mem_rd(mem_rd_b), .mem_rdata(mem_rdata),
    .busy(busy_b), .owner(owner_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tally write strobes seen at the end of the cycle, then move to the next cycle.
  task automatic cyc();
    if (mem_wr_a === 1'b1) cnt_a++;
    if (mem_wr_b === 1'b1) cnt_b++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = 3'b000; wr = 3'b000; lock = 3'b000;
    addr0 = 8'h00; addr1 = 8'h00; addr2 = 8'h00;
    wdata0 = 8'h00; wdata1 = 8'h00; wdata2 = 8'h00;
    mem_rdata = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
  endtask

  initial begin
    logic [2:0] rr_grant [4];
    logic [1:0] rr_owner [4];
    rr_grant = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_owner = '{2'd0, 2'd1, 2'd2, 2'd0};

    // Reset values
    clear_inputs();
    rst = 1'b1;
    cyc();
    #1;
    chk("rst_grant_a", 8'(grant_a), 8'h00);
    chk("rst_mem_wr_a", 8'(mem_wr_a), 8'h00);
    chk("rst_mem_rd_a", 8'(mem_rd_a), 8'h00);
    chk("rst_busy_a", 8'(busy_a), 8'h00);
    chk("rst_addr_a", mem_addr_a, 8'h00);
    chk("rst_wdata_a", mem_wdata_a, 8'h00);
    chk("rst_owner_a", 8'(owner_a), 8'h03);
    chk("rst_owner_b", 8'(owner_b), 8'h03);
    chk("rst_busy_b", 8'(busy_b), 8'h00);

    // Single write, no wait states
    do_reset();
    req = 3'b001; wr = 3'b001; addr0 = 8'h10; wdata0 = 8'hA5;
    #1;
    chk("w1_idle_grant", 8'(grant_a), 8'h00);
    chk("w1_idle_busy", 8'(busy_a), 8'h00);
    cyc();
    #1;
    chk("w1_grant", 8'(grant_a), 8'h01);
    chk("w1_mem_wr", 8'(mem_wr_a), 8'h01);
    chk("w1_mem_addr", mem_addr_a, 8'h10);
    chk("w1_mem_wdata", mem_wdata_a, 8'hA5);
    chk("w1_busy", 8'(busy_a), 8'h01);
    cyc();
    req = 3'b000;
    #1;
    chk("w1_after_grant", 8'(grant_a), 8'h00);
    chk("w1_after_wr", 8'(mem_wr_a), 8'h00);
    cyc();
    #1;
    chk("w1_idle_again", 8'(busy_a), 8'h00);
    chk("w1_idle_addr", mem_addr_a, 8'h00);
    cyc();
    chk("w1_wr_count", 8'(cnt_a), 8'h01);

    // Stack unit locked pair, CPU pending
    do_reset();
    req = 3'b010; lock = 3'b010; wr = 3'b010; addr1 = 8'hFD; wdata1 = 8'h55; addr0 = 8'h20;
    #1;
    chk("lk_idle_grant", 8'(grant_a), 8'h00);
    cyc();
    req = 3'b011;
    #1;
    chk("lk_beat1_grant", 8'(grant_a), 8'h02);
    chk("lk_beat1_addr", mem_addr_a, 8'hFD);
    chk("lk_beat1_wr", 8'(mem_wr_a), 8'h01);
    cyc();
    addr1 = 8'hFC;
    #1;
    chk("lk_beat2_grant", 8'(grant_a), 8'h02);
    chk("lk_beat2_addr", mem_addr_a, 8'hFC);
    cyc();
    #1;
    chk("lk_cpu_grant", 8'(grant_a), 8'h01);
    chk("lk_cpu_addr", mem_addr_a, 8'h20);
    chk("lk_cpu_rd", 8'(mem_rd_a), 8'h01);
    chk("lk_cpu_wr", 8'(mem_wr_a), 8'h00);
    cyc();
    clear_inputs();
    cyc();

    // Round-robin with all masters requesting
    do_reset();
    req = 3'b111;
    #1;
    chk("rr_idle_grant", 8'(grant_a), 8'h00);
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_grant_%0d", i), 8'(grant_a), 8'(rr_grant[i]));
      chk($sformatf("rr_owner_%0d", i), 8'(owner_a), 8'(rr_owner[i]));
      cyc();
    end
    clear_inputs();
    cyc();

    // Two-wait-state read by debug port
    do_reset();
    mem_rdata = 8'h3C; req = 3'b100;
    #1;
    chk("rd_idle_grant", 8'(grant_b), 8'h00);
    cyc();
    #1;
    chk("rd_c1_rd", 8'(mem_rd_b), 8'h01);
    chk("rd_c1_grant", 8'(grant_b), 8'h00);
    chk("rd_c1_owner", 8'(owner_b), 8'h02);
    cyc();
    #1;
    chk("rd_c2_rd", 8'(mem_rd_b), 8'h01);
    chk("rd_c2_grant", 8'(grant_b), 8'h00);
    cyc();
    #1;
    chk("rd_c3_grant", 8'(grant_b), 8'h04);
    chk("rd_c3_rdata", rdata_b, 8'h3C);
    chk("rd_c3_rd", 8'(mem_rd_b), 8'h01);
    chk("rd_c3_wr", 8'(mem_wr_b), 8'h00);
    cyc();
    req = 3'b000;
    cyc();
    #1;
    chk("rd_end_rd", 8'(mem_rd_b), 8'h00);
    chk("rd_end_busy", 8'(busy_b), 8'h00);
    chk("rd_end_owner", 8'(owner_b), 8'h03);

    // Abort: debug write withdrawn during its first wait cycle, CPU pending
    do_reset();
    req = 3'b100; wr = 3'b100; addr2 = 8'h40; wdata2 = 8'h77;
    #1;
    chk("ab_idle_busy", 8'(busy_b), 8'h00);
    cyc();
    req = 3'b001; wr = 3'b000; addr0 = 8'h21;
    #1;
    chk("ab_c1_grant", 8'(grant_b), 8'h00);
    chk("ab_c1_wr", 8'(mem_wr_b), 8'h00);
    cyc();
    #1;
    chk("ab_cpu_owner", 8'(owner_b), 8'h00);
    chk("ab_cpu_addr", mem_addr_b, 8'h21);
    chk("ab_cpu_g0", 8'(grant_b), 8'h00);
    cyc();
    #1;
    chk("ab_cpu_g1", 8'(grant_b), 8'h00);
    cyc();
    #1;
    chk("ab_cpu_grant", 8'(grant_b), 8'h01);
    cyc();
    req = 3'b000;
    cyc();
    chk("ab_wr_count", 8'(cnt_b), 8'h00);

    // Reset in the middle of a write access
    do_reset();
    req = 3'b001; wr = 3'b001; addr0 = 8'h33; wdata0 = 8'h99;
    cyc();
    #1;
    chk("mr_c1_grant", 8'(grant_b), 8'h00);
    cyc();
    rst = 1'b1;
    #1;
    chk("mr_rst_wr_a", 8'(mem_wr_a), 8'h00);
    chk("mr_rst_grant_a", 8'(grant_a), 8'h00);
    chk("mr_rst_wr_b", 8'(mem_wr_b), 8'h00);
    cyc();
    rst = 1'b0; req = 3'b010; wr = 3'b000; addr1 = 8'h44;
    #1;
    chk("mr_post_grant", 8'(grant_b), 8'h00);
    chk("mr_post_wr", 8'(mem_wr_b), 8'h00);
    chk("mr_post_owner", 8'(owner_b), 8'h03);
    chk("mr_post_busy", 8'(busy_b), 8'h00);
    cyc();
    #1;
    chk("mr_s1_owner", 8'(owner_b), 8'h01);
    chk("mr_s1_grant", 8'(grant_b), 8'h00);
    cyc();
    #1;
    chk("mr_s2_grant", 8'(grant_b), 8'h00);
    cyc();
    #1;
    chk("mr_s3_grant", 8'(grant_b), 8'h02);
    chk("mr_s3_addr", mem_addr_b, 8'h44);
    cyc();
    chk("mr_wr_count", 8'(cnt_b), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
- Arbitrates the single-port data-memory bus between three masters: 0 = CPU load/store datapath, 1 = stack unit (interrupt/call push and return pop), 2 = debug/DMA port.
- Sits between the masters and data memory, and produces the per-master bus_grant strobes the masters wait on.
- Uses round-robin arbitration with an optional bounded lock, so the stack unit's flag+PC pair completes back-to-back.
- Supports programmable memory wait states.

Parameters:
- WAIT_STATES, 0: extra cycles each access holds the bus before completing (0..15).
- LOCK_MAX, 2: maximum consecutive beats one master may keep with lock asserted (1..15).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  3  per-master access request; bit i = master i
- wr  in  3  per-master direction; 1 = write, 0 = read
- lock  in  3  per-master request to keep the bus for the next beat
- addr0, addr1, addr2  in  8 each  per-master address
- wdata0, wdata1, wdata2  in  8 each  per-master write data
- grant  out  3  one-hot, one-cycle completion strobe (the master's bus_grant)
- rdata  out  8  read data; equals mem_rdata, valid in the grant cycle
- mem_addr  out  8  memory address
- mem_wdata  out  8  memory write data
- mem_wr  out  1  memory write enable, single cycle
- mem_rd  out  1  memory read enable
- mem_rdata  in  8  memory combinational read data
- busy  out  1  an access is in progress
- owner  out  2  current owner index; 2'b11 when idle

Behaviour:
- Reset values:
  - grant = 0, mem_wr = 0, mem_rd = 0, busy = 0.
  - mem_addr = 0, mem_wdata = 0, owner = 2'b11.
  - Priority pointer = 0, wait counter = 0, lock counter = 0, state = ARB_IDLE.
- States: ARB_IDLE, ARB_ACCESS.
- ARB_IDLE:
  - If any req is high, pick the first requester at or after the priority pointer (modulo 3).
  - Register it as owner, load wait counter = WAIT_STATES, set lock counter = 1, go to ARB_ACCESS.
  - No grant is issued in ARB_IDLE.
- ARB_ACCESS:
  - mem_addr and mem_wdata are driven from the owner's addr/wdata; busy = 1.
  - mem_rd = ~wr[owner] for the entire access.
  - If wait counter != 0, decrement it.
  - If wait counter == 0, this is the completion cycle: grant[owner] = 1 and mem_wr = wr[owner] (this cycle only). The master samples rdata in the same cycle.
- Latency: request accepted in cycle n means grant in cycle n+1+WAIT_STATES. Each beat occupies WAIT_STATES+1 cycles in ARB_ACCESS.
- After completion, the owner continues if lock[owner] && req[owner] && lock counter < LOCK_MAX:
  - Same owner, wait counter reloaded, lock counter incremented.
  - The next beat starts on the next cycle with no idle gap.
- Otherwise the priority pointer becomes (owner+1) mod 3:
  - If any req is high at completion, re-arbitrate directly into a new ARB_ACCESS (no idle cycle), resetting lock counter to 1.
  - Else go to ARB_IDLE.
- Lock limit: once lock counter reaches LOCK_MAX, re-arbitration is forced even if lock is held. The same master may still win if it is the only requester.
- Abort: if req[owner] falls in ARB_ACCESS before the completion cycle, the access is abandoned.
  - No grant, no mem_wr.
  - The pointer is unchanged.
  - Re-arbitrate among the remaining requesters, or go to ARB_IDLE.
- Masters must hold req, wr, addr and wdata stable until their grant. Changes mid-access are ignored for arbitration; address and data are taken live.
- Idle outputs: mem_addr and mem_wdata are forced to 0 when not in ARB_ACCESS.
- Reset mid-access: the next cycle shows all reset values; no mem_wr is ever issued during or after the reset cycle.
- Simultaneous requests are resolved only by the priority pointer; there is no static priority.

Decomposition:
- Shared package (control definitions header):
  - Master ID constants: MST_CPU = 0, MST_STACK = 1, MST_DBG = 2.
  - OWNER_NONE = 2'b11.
  - Arbiter state encodings.
- One combinational sub-module, rr_pick3: inputs req[2:0] and pointer[1:0]; outputs a found flag and the winner index.

Test Plan:
- WAIT_STATES=0, single write: req0=1, wr0=1, addr0=0x10, wdata0=0xA5 at cycle 1 -> in cycle 2, grant=3'b001, mem_wr=1, mem_addr=0x10, mem_wdata=0xA5; mem_wr seen exactly once.
- Stack locked pair:
  - Stimulus: req1+lock1 with addr1 = 0xFD then 0xFC, while req0 is pending.
  - Expected: grant 3'b010 on two consecutive cycles, then 3'b001.
  - With lock held for 3 beats and LOCK_MAX=2: master 0 is granted after the second beat.
- Round-robin: all three req held high from reset -> grant sequence 001, 010, 100, 001, one grant per cycle with WAIT_STATES=0.
- WAIT_STATES=2 read: req2=1, wr2=0, with mem_rdata=0x3C -> mem_rd high for 3 cycles, grant=3'b100 in the third cycle, rdata=0x3C in that cycle.
- Abort: WAIT_STATES=2, req2 drops during the first wait cycle while req0 is pending -> no grant[2], no mem_wr; master 0 is granted 3 cycles later.
- Reset mid-access: rst=1 during a write access before completion -> next cycle grant=0, mem_wr=0, owner=2'b11, busy=0. After release, req1 alone is served first, with latency 1+WAIT_STATES.
